filter_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of the `cmacc` filter stage. It accepts a raster-order pixel stream (`data_i`/`valid_i`/`frame_i`) and buffers two image lines internally. For every input pixel that completes a fully in-image 3x3 neighbourhood, it presents all nine pixels in parallel with `valid_o`/`frame_o`, ready for the multiply-accumulate stage.

---
 rtl/filter_window_3x3_if.sv | 39 +++
 rtl/filter_window_3x3.sv | 217 +++++++++++++++++++++
 tb/tb_filter_window_3x3.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/filter_window_3x3_if.sv
// ----------------------------------------------------------------------------
// filter_window_3x3_if
//
// Pixel-stream and window bundle between a raster pixel source and the
// filter_window_3x3 neighbourhood generator.
//
// Signals:
//   data_i   source -> window gen   DATA_W    input pixel, qualified by valid_i
//   valid_i  source -> window gen   1         pixel strobe (no backpressure)
//   frame_i  source -> window gen   1         start of frame, with valid_i on (0,0)
//   win_o    window gen -> sink     9*DATA_W  3x3 window, element (r,c) at
//                                             [DATA_W*(3*r+c) +: DATA_W]
//   valid_o  window gen -> sink     1         window strobe
//   frame_o  window gen -> sink     1         first window of a frame
//
// Modports:
//   master : the pixel source / window consumer (testbench or upstream logic)
//   slave  : the window generator itself
// ----------------------------------------------------------------------------
interface filter_window_3x3_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]   data_i;
    logic                valid_i;
    logic                frame_i;
    logic [9*DATA_W-1:0] win_o;
    logic                valid_o;
    logic                frame_o;

    modport master (
        output data_i, valid_i, frame_i,
        input  win_o, valid_o, frame_o
    );

    modport slave (
        input  data_i, valid_i, frame_i,
        output win_o, valid_o, frame_o
    );
endinterface

// File: rtl/filter_window_3x3.sv
// ----------------------------------------------------------------------------
// filter_window_3x3
//
// Streaming 3x3 neighbourhood generator. Takes a raster-order pixel stream,
// keeps the two previous image lines in line-buffer RAMs, and for every pixel
// that completes a fully in-image 3x3 neighbourhood presents all nine pixels
// in parallel. No padding: a frame of IMG_W x IMG_H yields
// (IMG_W-2)*(IMG_H-2) windows.
//
// Parameters:
//   DATA_W  pixel width in bits
//   IMG_W   pixels per line (>= 3)
//   IMG_H   lines per frame (>= 3)
//
// Ports:
//   clock_i  in   single clock, rising edge
//   reset_i  in   synchronous, active-high reset
//   bus      slave modport of filter_window_3x3_if (pixel in, window out)
//
// Build option:
//   FILTER_WINDOW_OUT_REG_EN  when defined, adds one register stage on
//                             win_o/valid_o/frame_o (latency 2 instead of 1).
// ----------------------------------------------------------------------------
module filter_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    filter_window_3x3_if.slave   bus
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_EMIT  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_EMIT  = ROW_W'(2);

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    typedef logic [DATA_W-1:0] pix_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;

    // lb0 holds the previous line, lb1 the line before that.
    pix_t                lb0_mem [IMG_W];
    pix_t                lb1_mem [IMG_W];

    // Shift-register window: [row][col], row 0 oldest line, col 0 oldest column.
    pix_t                win_sr_q [3][3];
    pix_t                win_d    [3][3];

    logic [9*DATA_W-1:0] win_q;
    logic [9*DATA_W-1:0] win_flat_d;
    logic                valid_q;
    logic                frame_q;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic                accept;
    logic                emit;
    logic                first_win;
    logic                last_col;
    logic                last_pix;
    logic [COL_W-1:0]    col_eff;
    logic [ROW_W-1:0]    row_eff;
    pix_t                lb0_rd;
    pix_t                lb1_rd;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        accept     = 1'b0;
        col_eff    = col_q;
        row_eff    = row_q;
        col_d      = col_q;
        row_d      = row_q;
        win_flat_d = '0;

        // A valid pixel is taken in ACTIVE, or as the start of a new frame in
        // either state. frame_i forces position (0,0), which is how a resync
        // discards whatever partial frame was in progress.
        accept = bus.valid_i && (bus.frame_i || (state_q == ACTIVE));
        if (bus.frame_i) begin
            col_eff = '0;
            row_eff = '0;
        end

        last_col  = (col_eff == COL_LAST);
        last_pix  = last_col && (row_eff == ROW_LAST);
        emit      = accept && (row_eff >= ROW_EMIT) && (col_eff >= COL_EMIT);
        first_win = (row_eff == ROW_EMIT) && (col_eff == COL_EMIT);

        if (last_col) begin
            col_d = '0;
            row_d = last_pix ? '0 : row_eff + ROW_W'(1);
        end else begin
            col_d = col_eff + COL_W'(1);
            row_d = row_eff;
        end

        // Asynchronous read so the column above the incoming pixel is
        // available in the same cycle as data_i.
        lb0_rd = lb0_mem[col_eff];
        lb1_rd = lb1_mem[col_eff];

        // Next window: shift one column left and append the new column.
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_sr_q[r][1];
            win_d[r][1] = win_sr_q[r][2];
        end
        win_d[0][2] = lb1_rd;
        win_d[1][2] = lb0_rd;
        win_d[2][2] = bus.data_i;

        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_flat_d[DATA_W*(3*r+c) +: DATA_W] = win_d[r][c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers
    // ------------------------------------------------------------------
    // NOTE: the line-buffer RAMs are deliberately not reset; a location is
    // always rewritten in the current frame before it can reach a window.
    always_ff @(posedge clock_i) begin
        if (accept) begin
            lb0_mem[col_eff] <= bus.data_i;
            lb1_mem[col_eff] <= lb0_rd;
        end
    end

    // ------------------------------------------------------------------
    // FSM, counters, window and output registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= WAIT_SOF;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_sr_q[r][c] <= '0;
                end
            end
        end else begin
            case (state_q)
                WAIT_SOF: if (bus.valid_i && bus.frame_i) state_q <= ACTIVE;
                ACTIVE:   if (accept && last_pix)         state_q <= WAIT_SOF;
                default:                                  state_q <= WAIT_SOF;
            endcase

            if (accept) begin
                col_q    <= col_d;
                row_q    <= row_d;
                win_sr_q <= win_d;
            end

            // win_o only changes on an emitted window, so it holds across
            // gaps and across the non-emitting pixels at the image edges.
            valid_q <= emit;
            frame_q <= emit && first_win;
            if (emit) begin
                win_q <= win_flat_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
`ifdef FILTER_WINDOW_OUT_REG_EN
    logic [9*DATA_W-1:0] win_out_q;
    logic                valid_out_q;
    logic                frame_out_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            win_out_q   <= '0;
            valid_out_q <= 1'b0;
            frame_out_q <= 1'b0;
        end else begin
            win_out_q   <= win_q;
            valid_out_q <= valid_q;
            frame_out_q <= frame_q;
        end
    end

    assign bus.win_o   = win_out_q;
    assign bus.valid_o = valid_out_q;
    assign bus.frame_o = frame_out_q;
`else
    assign bus.win_o   = win_q;
    assign bus.valid_o = valid_q;
    assign bus.frame_o = frame_q;
`endif

endmodule

// File: tb/tb_filter_window_3x3.sv
// ----------------------------------------------------------------------------
// tb_filter_window_3x3
//
// Self-checking bench for filter_window_3x3 at IMG_W=4, IMG_H=3, DATA_W=8.
// The driver pushes the expected window into a scoreboard queue as it issues
// the completing pixel; an independent monitor pops and compares on every
// valid_o. Any window with nothing expected is reported.
// ----------------------------------------------------------------------------
module tb_filter_window_3x3;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int WIN_W  = 9 * DATA_W;

    typedef struct {
        logic [WIN_W-1:0] win;
        logic             frame;
    } exp_t;

    logic clk;
    logic rst;

    filter_window_3x3_if #(.DATA_W(DATA_W)) bus ();

    filter_window_3x3 #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_win    = 0;

    task automatic check(input string name, input logic [WIN_W-1:0] act,
                         input logic [WIN_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Window of a 4-wide frame whose top-left pixel value is 'first':
    // rows are 4 apart, columns 1 apart.
    function automatic logic [WIN_W-1:0] win_of(input int first);
        int offs [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        logic [WIN_W-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[DATA_W*k +: DATA_W] = DATA_W'(first + offs[k]);
        end
        return w;
    endfunction

    task automatic push(input int first, input logic frm);
        exp_t e;
        e.win   = win_of(first);
        e.frame = frm;
        exp_q.push_back(e);
    endtask

    task automatic send_pix(input int val, input logic frm);
        @(posedge clk); #1;
        bus.data_i  = DATA_W'(val);
        bus.valid_i = 1'b1;
        bus.frame_i = frm;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.valid_i = 1'b0;
            bus.frame_i = 1'b0;
        end
    endtask

    // 12-pixel frame base..base+11; pixels 10 and 11 complete the two windows.
    task automatic send_frame(input int base, input bit gaps);
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            send_pix(base + i, i == 0);
            if (i == 10) push(base, 1'b1);
            if (i == 11) push(base + 1, 1'b0);
            if (gaps) idle(1);
        end
    endtask

    task automatic drain(input string name);
        idle(6);
        check(name, WIN_W'(exp_q.size()), WIN_W'(0));
    endtask

    // Monitor: compares every presented window against the scoreboard.
    always @(negedge clk) begin
        if (bus.frame_o && !bus.valid_o) begin
            check("frame_o_without_valid_o", WIN_W'(bus.frame_o), WIN_W'(0));
        end
        if (bus.valid_o) begin
            n_win++;
            if (exp_q.size() == 0) begin
                check("unexpected_window", WIN_W'(bus.valid_o), WIN_W'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("window", bus.win_o, e.win);
                check("frame_o", WIN_W'(bus.frame_o), WIN_W'(e.frame));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int saved;
        rst         = 1'b1;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.frame_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_win_o",   bus.win_o,            WIN_W'(0));
        check("reset_valid_o", WIN_W'(bus.valid_o),  WIN_W'(0));
        check("reset_frame_o", WIN_W'(bus.frame_o),  WIN_W'(0));

        // 1: continuous frame 0..11
        send_frame(0, 1'b0);
        drain("drain_continuous");

        // 2: same frame with a gap after every pixel
        send_frame(0, 1'b1);
        drain("drain_gapped");

        // 3: frame_i without valid_i, then pixels without any frame_i: dropped
        saved = n_win;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.frame_i = 1'b1;
        for (int i = 0; i < IMG_W * IMG_H; i++) send_pix(i, 1'b0);
        idle(6);
        check("no_sof_no_windows", WIN_W'(n_win), WIN_W'(saved));
        send_frame(0, 1'b0);
        drain("drain_after_no_sof");

        // 4: resync at pixel 6, then a fresh frame 100..111
        for (int i = 0; i < 6; i++) send_pix(i, i == 0);
        send_frame(100, 1'b0);
        drain("drain_resync");

        // 5: reset mid-frame, asserted together with a completing pixel
        for (int i = 0; i < 10; i++) send_pix(50 + i, i == 0);
        @(posedge clk); #1;
        bus.data_i  = DATA_W'(60);
        bus.valid_i = 1'b1;
        bus.frame_i = 1'b0;
        rst         = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        @(negedge clk);
        check("midreset_valid_o", WIN_W'(bus.valid_o), WIN_W'(0));
        check("midreset_frame_o", WIN_W'(bus.frame_o), WIN_W'(0));
        check("midreset_win_o",   bus.win_o,           WIN_W'(0));
        saved = n_win;
        for (int i = 0; i < 5; i++) send_pix(70 + i, 1'b0);
        idle(6);
        check("midreset_input_ignored", WIN_W'(n_win), WIN_W'(saved));
        send_frame(20, 1'b0);
        drain("drain_after_reset");

        // 6: two back-to-back frames
        saved = n_win;
        send_frame(30, 1'b0);
        send_frame(60, 1'b0);
        drain("drain_two_frames");
        check("two_frames_count", WIN_W'(n_win - saved), WIN_W'(4));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
